decodificador_pt2272_param: RTL and testbench

- Parametrised successor to the fixed 8-bit-address / 4-bit-data PT2272 decoder.
- Sits on the receive side of the serial link, paired with the PT2262-style encoder.
- Measures pulse widths on the serial line, recovers frames of `ADDR_W+DATA_W` bits, and requires `REPEAT` consecutive identical address-matched frames before presenting data.
- Output mode is selectable at compile time: latched (L-type) or momentary (M-type).

---
 rtl/decodificador_pkg.sv | 38 +++
 rtl/sincronizador_borda.sv | 41 ++++
 rtl/decodificador_pt2272_param.sv | 208 ++++++++++++++++++++
 tb/tb_decodificador_pt2272_param.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/decodificador_pkg.sv
// -----------------------------------------------------------------------------
// decodificador_pkg
// Shared types and constants for the parametrised PT2272 decoder.
//   state_t   : frame-recovery FSM states
//   width_t   : classification of a measured pulse width
//   SHORT_*/LONG_*/SYNC_MIN/SAT : window bounds in units of the oscillator
//               period alpha (multiply by ALPHA to get clk cycles)
//   classify(): maps a width in clk cycles onto width_t
// -----------------------------------------------------------------------------
package decodificador_pkg;

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_HI    = 2'd1,
        S_LO    = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        W_SHORT = 2'd0,
        W_LONG  = 2'd1,
        W_BAD   = 2'd2
    } width_t;

    localparam int unsigned SHORT_MIN = 2;
    localparam int unsigned SHORT_MAX = 6;
    localparam int unsigned LONG_MIN  = 9;
    localparam int unsigned LONG_MAX  = 15;
    localparam int unsigned SYNC_MIN  = 64;
    localparam int unsigned SAT       = 128;

    function automatic width_t classify(input int unsigned w, input int unsigned alpha);
        if (w >= SHORT_MIN * alpha && w <= SHORT_MAX * alpha) return W_SHORT;
        if (w >= LONG_MIN * alpha && w <= LONG_MAX * alpha)   return W_LONG;
        return W_BAD;
    endfunction

endpackage

// File: rtl/sincronizador_borda.sv
// -----------------------------------------------------------------------------
// sincronizador_borda
// Two-flop synchroniser for an asynchronous input, followed by an edge-detect
// register. rise/fall are registered one-cycle pulses aligned with level.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   din   in  asynchronous serial input
//   level out synchronised level (same cycle alignment as rise/fall)
//   rise  out one-cycle pulse on a 0->1 transition
//   fall  out one-cycle pulse on a 1->0 transition
// -----------------------------------------------------------------------------
module sincronizador_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1, sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample its
            // pre-edge input; blocking ones would collapse the chain into wires.
            sync1 <= din;
            sync2 <= sync1;
            level <= sync2;
            rise  <= sync2 & ~level;
            fall  <= ~sync2 & level;
        end
    end

endmodule

// File: rtl/decodificador_pt2272_param.sv
// -----------------------------------------------------------------------------
// decodificador_pt2272_param
// Receive-side decoder for PT2262-style serial frames. Measures high/low
// widths on cod_i, recovers ADDR_W+DATA_W bit frames (sync, address MSB
// first, data MSB first) and presents the data once REPEAT consecutive
// identical address-matched frames have been seen. dv is held for HOLD_CYC
// cycles after the latest acceptance.
//   clk       in  system clock
//   reset     in  asynchronous active-low reset
//   A         in  local address, compared only at frame check
//   cod_i     in  serial code input, asynchronous to clk
//   D         out received data
//   dv        out data valid
//   frame_err out one-cycle pulse on a malformed symbol
// Compile-time option PT2272_LATCH_EN: when defined D keeps its last accepted
// value after dv falls (L-type); otherwise D clears together with dv (M-type).
// -----------------------------------------------------------------------------
module decodificador_pt2272_param
    import decodificador_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 4,
    parameter int ALPHA    = 4,
    parameter int REPEAT   = 2,
    parameter int HOLD_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A,
    input  logic              cod_i,
    output logic [DATA_W-1:0] D,
    output logic              dv,
    output logic              frame_err
);

    localparam int N  = ADDR_W + DATA_W;
    localparam int CW = $clog2(SAT * ALPHA + 1);
    localparam int BW = $clog2(N + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int MW = 3;

    localparam logic [CW-1:0] CNT_SAT  = CW'(SAT * ALPHA);
    localparam logic [CW-1:0] CNT_SYNC = CW'(SYNC_MIN * ALPHA);
    localparam logic [CW-1:0] CNT_MAX  = CW'(LONG_MAX * ALPHA);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
    localparam logic [MW-1:0] REP      = MW'(REPEAT);
    localparam logic [HW-1:0] HOLD_END = HW'(HOLD_CYC - 1);

    logic level, rise, fall;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n, cnt_inc, hi_w, hi_w_n;
    logic [N-1:0]      shreg, shreg_n, prev_word, prev_word_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [MW-1:0]     match, match_n;
    logic [HW-1:0]     hold, hold_n;
    logic [DATA_W-1:0] d_n;
    logic              dv_n, err_n, accept;
    width_t            hi_cls, lo_cls;

    sincronizador_borda u_sync (
        .clk   (clk),
        .rst_n (reset),
        .din   (cod_i),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_HUNT;
        else        state <= state_n;
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_n     = state;
        cnt_n       = cnt;
        hi_w_n      = hi_w;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        match_n     = match;
        prev_word_n = prev_word;
        hold_n      = hold;
        d_n         = D;
        dv_n        = dv;
        err_n       = 1'b0;
        accept      = 1'b0;
        cnt_inc     = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
        hi_cls      = classify(int'(hi_w), ALPHA);
        lo_cls      = classify(int'(cnt), ALPHA);

        case (state)
            S_HUNT: begin
                // Idle low counts as sync low, so the first frame of a burst
                // needs no leading sync pulse.
                if (rise) begin
                    if (cnt >= CNT_SYNC) begin
                        state_n   = S_HI;
                        bit_cnt_n = '0;
                        cnt_n     = CW'(1);
                    end else begin
                        cnt_n = '0;
                    end
                end else if (level) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_HI: begin
                if (fall) begin
                    cnt_n = CW'(1);
                    if (cnt > CNT_MAX) begin
                        err_n   = 1'b1;
                        state_n = S_HUNT;
                    end else begin
                        hi_w_n  = cnt;
                        state_n = S_LO;
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_LO: begin
                if (rise) begin
                    if ((hi_cls == W_SHORT && lo_cls == W_LONG) ||
                        (hi_cls == W_LONG && lo_cls == W_SHORT)) begin
                        shreg_n   = {shreg[N-2:0], hi_cls == W_LONG};
                        bit_cnt_n = bit_cnt + BW'(1);
                        cnt_n     = CW'(1);
                        state_n   = (bit_cnt == LAST_BIT) ? S_CHECK : S_HI;
                    end else begin
                        err_n   = 1'b1;
                        cnt_n   = '0;
                        state_n = S_HUNT;
                    end
                end else if (cnt > CNT_MAX) begin
                    // Keep counting the low phase: a premature sync still
                    // reaches the sync threshold in S_HUNT.
                    err_n   = 1'b1;
                    cnt_n   = cnt_inc;
                    state_n = S_HUNT;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_CHECK: begin
                state_n = S_HUNT;
                cnt_n   = '0;
                if (shreg[N-1:DATA_W] != A) begin
                    match_n = '0;
                end else if (shreg == prev_word) begin
                    match_n = (match == REP) ? match : match + MW'(1);
                end else begin
                    match_n     = MW'(1);
                    prev_word_n = shreg;
                end
                accept = (shreg[N-1:DATA_W] == A) && (match_n == REP);
            end
            default: state_n = S_HUNT;
        endcase

        // A fresh acceptance outranks the hold timeout in the same cycle.
        if (accept) begin
            d_n    = shreg[DATA_W-1:0];
            dv_n   = 1'b1;
            hold_n = '0;
        end else if (dv && hold == HOLD_END) begin
            dv_n    = 1'b0;
            match_n = '0;
            hold_n  = '0;
`ifndef PT2272_LATCH_EN
            d_n     = '0;
`endif
        end else if (dv) begin
            hold_n = hold + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            hi_w      <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            match     <= '0;
            prev_word <= '0;
            hold      <= '0;
            D         <= '0;
            dv        <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            hi_w      <= hi_w_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            match     <= match_n;
            prev_word <= prev_word_n;
            hold      <= hold_n;
            D         <= d_n;
            dv        <= dv_n;
            frame_err <= err_n;
        end
    end

endmodule

// File: tb/tb_decodificador_pt2272_param.sv
// -----------------------------------------------------------------------------
// tb_decodificador_pt2272_param
// Scoreboard bench for decodificador_pt2272_param (ADDR_W=8, DATA_W=4,
// ALPHA=4, REPEAT=2, HOLD_CYC=4096). The stimulus process pushes every
// expected {cycle, dv, D} change and every expected frame_err cycle; an
// independent monitor pops and compares whenever the outputs move.
// Honours PT2272_LATCH_EN for the value D takes when dv falls.
// -----------------------------------------------------------------------------
module tb_decodificador_pt2272_param;

    localparam int ALPHA    = 4;
    localparam int HOLD_CYC = 4096;

    typedef struct {
        int         cyc;
        logic       dv;
        logic [3:0] d;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       cod_i = 1'b0;
    logic [7:0] a_loc = 8'hCA;
    logic [3:0] d_out;
    logic       dv;
    logic       frame_err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_acc = 0;
    bit   mon_en = 1'b0;
    exp_t chg_q[$];
    int   err_q[$];

    logic [4:0] prev_out = '0;
    logic       prev_err = 1'b0;
    int         err_width = 0;

    decodificador_pt2272_param dut (
        .clk       (clk),
        .reset     (reset),
        .A         (a_loc),
        .cod_i     (cod_i),
        .D         (d_out),
        .dv        (dv),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] fall_d(input logic [3:0] last);
`ifdef PT2272_LATCH_EN
        return last;
`else
        return 4'h0;
`endif
    endfunction

    // Monitor: compares on every change of {dv, D} and every frame_err pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            if ({dv, d_out} != prev_out) begin
                if (chg_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got dv=%0d D=%0h at cycle %0d", dv, d_out, cyc);
                end else begin
                    exp_t e;
                    e = chg_q.pop_front();
                    check("out_cycle", cyc, e.cyc);
                    check("out_dv", int'(dv), int'(e.dv));
                    check("out_d", int'(d_out), int'(e.d));
                end
            end
            if (frame_err && !prev_err) begin
                if (err_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame_err: got pulse at cycle %0d", cyc);
                end else begin
                    check("frame_err_cycle", cyc, err_q.pop_front());
                end
            end
            if (frame_err) err_width <= err_width + 1;
            if (!frame_err && prev_err) begin
                check("frame_err_width", err_width, 1);
                err_width <= 0;
            end
            prev_out <= {dv, d_out};
            prev_err <= frame_err;
        end
    end

    task automatic drive(input logic v, input int n);
        cod_i = v;
        repeat (n) @(negedge clk);
    endtask

    // One frame (12 bits) followed by its trailing sync. bad_bit >= 0 replaces
    // that bit by a 7a-high/9a-low symbol. sh/lg are short/long widths in alpha.
    task automatic send_frame(input logic [11:0] word, input int bad_bit,
                              input bit exp_chg, input logic [3:0] exp_d,
                              input int sh, input int lg);
        bit err_pend;
        err_pend = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            int hi;
            int lo;
            hi = word[i] ? lg : sh;
            lo = word[i] ? sh : lg;
            if (i == bad_bit) begin
                hi = 7;
                lo = 9;
            end
            if (err_pend) begin
                err_q.push_back(cyc + 4);
                err_pend = 1'b0;
            end
            drive(1'b1, hi * ALPHA);
            drive(1'b0, lo * ALPHA);
            if (i == bad_bit) err_pend = 1'b1;
        end
        if (err_pend) err_q.push_back(cyc + 4);
        if (exp_chg) begin
            last_acc = cyc + 5;
            chg_q.push_back('{last_acc, 1'b1, exp_d});
        end
        drive(1'b1, 4 * ALPHA);
        drive(1'b0, 124 * ALPHA);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_dv", int'(dv), 0);
        check("reset_d", int'(d_out), 0);
        check("reset_frame_err", int'(frame_err), 0);
        mon_en = 1'b1;
        reset  = 1'b1;
        drive(1'b0, 130 * ALPHA);

        // Two matching frames: acceptance only after the second.
        send_frame(12'hCAA, -1, 1'b0, 4'h0, 4, 12);
        send_frame(12'hCAA, -1, 1'b1, 4'hA, 4, 12);
        // Transmission stops: dv falls HOLD_CYC cycles after acceptance.
        chg_q.push_back('{last_acc + HOLD_CYC, 1'b0, fall_d(4'hA)});
        drive(1'b0, HOLD_CYC + 200);

        // Address mismatch: no dv, no frame_err.
        a_loc = 8'hAA;
        send_frame(12'hCAA, -1, 1'b0, 4'h0, 4, 12);
        send_frame(12'hCAA, -1, 1'b0, 4'h0, 4, 12);
        a_loc = 8'hCA;

        // Malformed 7a high pulse, then two good frames.
        send_frame(12'hCAA, 9, 1'b0, 4'h0, 4, 12);
        send_frame(12'hCAA, -1, 1'b0, 4'h0, 4, 12);
        send_frame(12'hCAA, -1, 1'b1, 4'hA, 4, 12);
        chg_q.push_back('{last_acc + HOLD_CYC, 1'b0, fall_d(4'hA)});
        drive(1'b0, HOLD_CYC + 200);

        // Data change needs its own REPEAT run.
        send_frame(12'hCAA, -1, 1'b0, 4'h0, 4, 12);
        send_frame(12'hCAA, -1, 1'b1, 4'hA, 4, 12);
        send_frame(12'hCAF, -1, 1'b0, 4'h0, 4, 12);
        send_frame(12'hCAF, -1, 1'b1, 4'hF, 4, 12);

        // Reset in the middle of a frame clears outputs at once.
        drive(1'b1, 12 * ALPHA);
        drive(1'b0, 4 * ALPHA);
        drive(1'b1, 4 * ALPHA);
        drive(1'b0, 6 * ALPHA);
        @(posedge clk);
        #2;
        reset = 1'b0;
        chg_q.push_back('{cyc, 1'b0, 4'h0});
        #1;
        check("midreset_dv", int'(dv), 0);
        check("midreset_d", int'(d_out), 0);
        @(negedge clk);
        cod_i = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 130 * ALPHA);
        // Frames at the edges of the classification windows.
        send_frame(12'hCA3, -1, 1'b0, 4'h0, 2, 15);
        send_frame(12'hCA3, -1, 1'b1, 4'h3, 6, 9);
        repeat (10) @(negedge clk);

        check("pending_outputs", chg_q.size(), 0);
        check("pending_frame_errs", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
